// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single SDRAM controller command port between the instruction
// fetch path (I, read-only) and the data path (D, read/write). Only one
// transaction is outstanding at a time. D wins contested arbitration unless
// I has already lost STARVE_MAX contested rounds in a row, in which case I is
// forced through.
//
// Transaction flow: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             fetch request and address, held until i_done
//   i_rdata/i_done           fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_be             data request and command, held until d_done
//   d_rdata/d_done           load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         registered command toward the SDRAM controller
//   mem_ack                  controller accepted the command
//   mem_rvalid/mem_rdata     read data valid / write completed
//   busy                     a transaction is in progress
//   err                      sticky: mem_rvalid arrived when none was expected
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic [DW-1:0]     i_rdata,
    output logic              i_done,
    // data side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic [DW-1:0]     d_rdata,
    output logic              d_done,
    // SDRAM controller command port
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata,
    // status
    output logic              busy,
    output logic              err
);

    localparam int            BW         = DW / 8;
    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t          state;
    state_t          state_nxt;
    owner_t          owner;
    logic [3:0]      starve_cnt;
    logic            grant_d;
    logic            start;
    logic            capture;

    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [BW-1:0]   cmd_be;
    logic [DW-1:0]   i_rdata_q;
    logic [DW-1:0]   d_rdata_q;
    logic            err_q;

    // Arbitration: D wins unless I has been passed over STARVE_MAX times in
    // a row while both were requesting.
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        grant_d = 1'b0;
        if (d_req && !i_req)
            grant_d = 1'b1;
        else if (d_req && i_req)
            grant_d = (starve_cnt != STARVE_LIM);
    end

    assign start = (state == IDLE) && (i_req || d_req);

    // Read data is taken either together with the ack or later in WAIT.
    assign capture = ((state == ISSUE) && mem_ack && mem_rvalid) ||
                     ((state == WAIT)  && mem_rvalid);

    // ---------------------------------------------------------------- FSM: state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nxt = ISSUE;
            ISSUE:   if (mem_ack)        state_nxt = mem_rvalid ? RESP : WAIT;
            WAIT:    if (mem_rvalid)     state_nxt = RESP;
            RESP:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        mem_req = (state == ISSUE);
        busy    = (state != IDLE);
        i_done  = (state == RESP) && (owner == OWN_I);
        d_done  = (state == RESP) && (owner == OWN_D);
    end

    // ---------------------------------------------------------------- command / response datapath
    // NOTE: the command and read-data registers are reset as well, because
    // every output must read 0 while rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_I;
            starve_cnt <= '0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_be     <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start) begin
                owner     <= grant_d ? OWN_D : OWN_I;
                cmd_we    <= grant_d && d_we;
                cmd_addr  <= grant_d ? d_addr : i_addr;
                cmd_wdata <= grant_d ? d_wdata : '0;
                cmd_be    <= grant_d ? d_be : '1;
                // Only contested rounds count toward starvation; an I grant
                // of either kind restarts the count.
                if (i_req && d_req)
                    starve_cnt <= grant_d ? starve_cnt + 4'd1 : 4'd0;
                else if (i_req)
                    starve_cnt <= 4'd0;
            end

            // Writes leave the owner's rdata untouched so it keeps the last load.
            if (capture) begin
                if (owner == OWN_I)
                    i_rdata_q <= mem_rdata;
                else if (!cmd_we)
                    d_rdata_q <= mem_rdata;
            end

            if (mem_rvalid && ((state == IDLE) || (state == RESP)))
                err_q <= 1'b1;
        end
    end

    assign mem_we    = cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign mem_be    = cmd_be;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The bench plays both requesters
// and the SDRAM controller. A small reference model predicts, from the
// requests present when a command appears, which side must win and what the
// command must carry, and the controller side predicts which done pulse and
// read data must follow each response.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW         = 24;
    localparam int DW         = 32;
    localparam int BW         = DW / 8;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_done;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [BW-1:0]   d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_done;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [BW-1:0]   mem_be;
    logic            mem_ack;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err        (err)
    );

    // ------------------------------------------------------------ bookkeeping
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ model / controller state
    int              streak;          // contested D wins since I last won
    int              exp_owner;       // 1 = I, 2 = D
    int              pend_side;       // done expected in the next observed cycle
    bit              pend_read;
    logic [DW-1:0]   pend_data;
    bit              exp_err;
    bit              prev_mem_req;
    logic [DW-1:0]   prev_i_rdata;
    logic [DW-1:0]   prev_d_rdata;
    logic [60:0]     cmd_snap;        // {we, be, addr, wdata} at command start
    bit              cmd_we_s;
    int              req_hi_cnt;
    int              grants;

    int              c_phase;         // 0 = waiting for command, 1 = waiting to return rvalid
    int              c_cnt;
    int              ack_dly;
    int              rv_dly;
    logic [DW-1:0]   rsp_data;
    int              ack_cnt;
    logic            ack_we;
    logic [AW-1:0]   ack_addr;
    logic [DW-1:0]   ack_wdata;
    logic [BW-1:0]   ack_be;

    int              i_done_cnt;
    int              d_done_cnt;
    int              last_done_cyc;
    logic [DW-1:0]   last_i_data;
    logic [DW-1:0]   last_d_data;

    bit              drop_on_done;
    bit              rand_req;
    bit              rand_ctl;
    bit              log_grants;
    int              grant_log[$];

    task automatic reset_model();
        streak       = 0;
        exp_owner    = 0;
        pend_side    = 0;
        pend_read    = 1'b0;
        exp_err      = 1'b0;
        prev_mem_req = 1'b0;
        prev_i_rdata = '0;
        prev_d_rdata = '0;
        c_phase      = 0;
        c_cnt        = 0;
    endtask

    // One clock: observe the DUT just after the edge, then drive the
    // requesters and the controller for the rest of the cycle.
    task automatic cycle();
        int win;
        @(posedge clk);
        #1;
        cyc++;

        // ---- response checks
        check("i_done", 64'(i_done), 64'(pend_side == 1));
        check("d_done", 64'(d_done), 64'(pend_side == 2));
        if (pend_side == 1 && pend_read) check("i_rdata", 64'(i_rdata), 64'(pend_data));
        if (pend_side == 2 && pend_read) check("d_rdata", 64'(d_rdata), 64'(pend_data));
        if (!i_done) check("i_rdata hold", 64'(i_rdata), 64'(prev_i_rdata));
        if (!d_done) check("d_rdata hold", 64'(d_rdata), 64'(prev_d_rdata));
        check("err", 64'(err), 64'(exp_err));
        pend_side = 0;

        if (i_done) begin
            i_done_cnt++;
            last_done_cyc = cyc;
            last_i_data   = i_rdata;
            if (drop_on_done) i_req = 1'b0;
        end
        if (d_done) begin
            d_done_cnt++;
            last_done_cyc = cyc;
            last_d_data   = d_rdata;
            if (drop_on_done) d_req = 1'b0;
        end
        prev_i_rdata = i_rdata;
        prev_d_rdata = d_rdata;

        // ---- new command: predict the winner from the requests it sampled
        if (mem_req && !prev_mem_req) begin
            check("grant had a requester", 64'(i_req || d_req), 64'd1);
            if (i_req && d_req) begin
                if (streak == STARVE_MAX) begin
                    win    = 1;
                    streak = 0;
                end else begin
                    win    = 2;
                    streak = streak + 1;
                end
            end else if (i_req) begin
                win    = 1;
                streak = 0;
            end else begin
                win = 2;
            end
            exp_owner = win;
            grants++;
            if (log_grants) grant_log.push_back((mem_addr == 24'h000100) ? 1 : 2);
            if (win == 1) begin
                check("cmd addr (I)", 64'(mem_addr), 64'(i_addr));
                check("cmd we (I)",   64'(mem_we),   64'd0);
                check("cmd be (I)",   64'(mem_be),   64'hF);
            end else begin
                check("cmd addr (D)", 64'(mem_addr), 64'(d_addr));
                check("cmd we (D)",   64'(mem_we),   64'(d_we));
                check("cmd be (D)",   64'(mem_be),   64'(d_be));
                if (d_we) check("cmd wdata (D)", 64'(mem_wdata), 64'(d_wdata));
            end
            cmd_snap   = {mem_we, mem_be, mem_addr, mem_wdata};
            cmd_we_s   = mem_we;
            c_phase    = 0;
            c_cnt      = 0;
            req_hi_cnt = 0;
            if (rand_ctl) begin
                ack_dly  = $urandom_range(0, 3);
                rv_dly   = $urandom_range(0, 3);
                rsp_data = $urandom;
            end
        end else if (mem_req) begin
            check("cmd stable", 64'({mem_we, mem_be, mem_addr, mem_wdata}), 64'(cmd_snap));
        end
        if (mem_req) req_hi_cnt++;
        prev_mem_req = mem_req;

        // ---- random requesters (only when not already requesting)
        if (rand_req) begin
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_addr = AW'($urandom);
                i_req  = 1'b1;
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = AW'($urandom);
                d_wdata = $urandom;
                d_be    = BW'($urandom);
                d_req   = 1'b1;
            end
        end

        // ---- controller
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (c_phase == 1) begin
            if (c_cnt == rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_data;
                pend_side  = exp_owner;
                pend_read  = !cmd_we_s;
                pend_data  = rsp_data;
                c_phase    = 0;
            end else begin
                c_cnt++;
            end
        end else if (mem_req) begin
            if (c_cnt == ack_dly) begin
                mem_ack   = 1'b1;
                ack_cnt++;
                ack_we    = mem_we;
                ack_addr  = mem_addr;
                ack_wdata = mem_wdata;
                ack_be    = mem_be;
                if (rv_dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp_data;
                    pend_side  = exp_owner;
                    pend_read  = !cmd_we_s;
                    pend_data  = rsp_data;
                end else begin
                    c_phase = 1;
                    c_cnt   = 1;
                end
            end else begin
                c_cnt++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req"},   64'(mem_req),   64'd0);
        check({tag, " mem_we"},    64'(mem_we),    64'd0);
        check({tag, " mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, " mem_be"},    64'(mem_be),    64'd0);
        check({tag, " i_done"},    64'(i_done),    64'd0);
        check({tag, " d_done"},    64'(d_done),    64'd0);
        check({tag, " i_rdata"},   64'(i_rdata),   64'd0);
        check({tag, " d_rdata"},   64'(d_rdata),   64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " err"},       64'(err),       64'd0);
    endtask

    // ------------------------------------------------------------ directed vectors
    typedef struct {
        bit              is_d;
        bit              we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [BW-1:0]   be;
        int              ack_dly;
        int              rv_dly;
        logic [DW-1:0]   rdata;
        logic [BW-1:0]   exp_be;
        int              exp_lat;    // cycles from request to done
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input string nm);
        int  start_cyc;
        int  i0;
        int  d0;
        int  a0;
        bit  seen;
        ack_dly  = v.ack_dly;
        rv_dly   = v.rv_dly;
        rsp_data = v.rdata;
        i0 = i_done_cnt;
        d0 = d_done_cnt;
        a0 = ack_cnt;
        if (v.is_d) begin
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_be    = v.be;
            d_req   = 1'b1;
        end else begin
            i_addr = v.addr;
            i_req  = 1'b1;
        end
        start_cyc = cyc;
        seen      = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (i_done_cnt != i0 || d_done_cnt != d0) seen = 1'b1;
        end
        check({nm, " completed"}, 64'(seen), 64'd1);
        check({nm, " latency"}, 64'(last_done_cyc - start_cyc), 64'(v.exp_lat));
        check({nm, " i_done count"}, 64'(i_done_cnt - i0), 64'(v.is_d ? 0 : 1));
        check({nm, " d_done count"}, 64'(d_done_cnt - d0), 64'(v.is_d ? 1 : 0));
        check({nm, " ack count"}, 64'(ack_cnt - a0), 64'd1);
        check({nm, " mem_we"}, 64'(ack_we), 64'(v.we));
        check({nm, " mem_addr"}, 64'(ack_addr), 64'(v.addr));
        check({nm, " mem_be"}, 64'(ack_be), 64'(v.exp_be));
        if (v.we) check({nm, " mem_wdata"}, 64'(ack_wdata), 64'(v.wdata));
        if (!v.is_d) check({nm, " i_rdata"}, 64'(last_i_data), 64'(v.rdata));
        else if (!v.we) check({nm, " d_rdata"}, 64'(last_d_data), 64'(v.rdata));
        cycle();
        cycle();
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        int d0;
        int g0;
        int dn0;
        bit ok;

        vecs[0] = '{1'b0, 1'b0, 24'h000100, 32'h0,        4'h0, 0, 2, 32'hDEADBEEF, 4'hF, 4};
        vecs[1] = '{1'b1, 1'b1, 24'h000010, 32'hA5A5A5A5, 4'h3, 0, 0, 32'h0,        4'h3, 2};
        vecs[2] = '{1'b1, 1'b0, 24'h123456, 32'h0,        4'hF, 1, 1, 32'h13579BDF, 4'hF, 4};
        vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF, 32'h0,        4'h0, 3, 2, 32'h0,        4'hF, 7};
        vecs[4] = '{1'b1, 1'b1, 24'hABCDEF, 32'h0,        4'h8, 2, 4, 32'h0,        4'h8, 8};
        vecs[5] = '{1'b1, 1'b0, 24'h000000, 32'h0,        4'hF, 0, 1, 32'hFFFFFFFF, 4'hF, 3};
        vecs[6] = '{1'b0, 1'b0, 24'h000004, 32'h0,        4'h0, 0, 0, 32'h01234567, 4'hF, 2};

        rst        = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        ack_dly    = 0;
        rv_dly     = 1;
        rsp_data   = '0;
        ack_cnt    = 0;
        i_done_cnt = 0;
        d_done_cnt = 0;
        grants     = 0;
        last_done_cyc = 0;
        drop_on_done  = 1'b1;
        rand_req      = 1'b0;
        rand_ctl      = 1'b0;
        log_grants    = 1'b0;
        reset_model();

        // ---- reset state
        #1;
        check_all_zero("reset");
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // ---- single-transaction vectors
        for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // ---- starvation guard: both requesters held high continuously
        ack_dly      = 0;
        rv_dly       = 0;
        rsp_data     = 32'h5555AAAA;
        i_addr       = 24'h000100;
        d_addr       = 24'h000200;
        d_we         = 1'b0;
        d_be         = 4'hF;
        drop_on_done = 1'b0;
        log_grants   = 1'b1;
        grant_log.delete();
        i_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 200 && grant_log.size() < 10; k++) cycle();
        i_req        = 1'b0;
        d_req        = 1'b0;
        drop_on_done = 1'b1;
        log_grants   = 1'b0;
        check("starve grant count", 64'(grant_log.size()), 64'd10);
        for (int k = 0; k < grant_log.size() && k < 10; k++)
            check($sformatf("starve grant %0d", k), 64'(grant_log[k]), 64'((k % 5 == 4) ? 1 : 2));
        for (int k = 0; k < 20 && (busy || pend_side != 0); k++) cycle();
        cycle();
        check("starve drained", 64'(busy), 64'd0);

        // ---- controller stalls ack for 7 cycles; D inputs change meanwhile
        ack_dly  = 7;
        rv_dly   = 1;
        rsp_data = 32'h0BADF00D;
        d_we     = 1'b0;
        d_addr   = 24'h000ABC;
        d_wdata  = '0;
        d_be     = 4'hF;
        d_req    = 1'b1;
        d0       = d_done_cnt;
        cycle();
        d_addr  = 24'h000777;
        d_we    = 1'b1;
        d_be    = 4'h1;
        d_wdata = 32'hFFFF0000;
        for (int k = 0; k < 30 && d_done_cnt == d0; k++) cycle();
        check("stall mem_req cycles", 64'(req_hi_cnt), 64'd8);
        check("stall ack addr", 64'(ack_addr), 64'h000ABC);
        check("stall ack we", 64'(ack_we), 64'd0);
        check("stall done", 64'(d_done_cnt - d0), 64'd1);
        check("stall rdata", 64'(last_d_data), 64'h0BADF00D);
        cycle();
        cycle();

        // ---- reset while in WAIT
        ack_dly  = 0;
        rv_dly   = 5;
        rsp_data = 32'h77777777;
        d_we     = 1'b0;
        d_addr   = 24'h000321;
        d_be     = 4'hF;
        d_req    = 1'b1;
        ok       = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            cycle();
            if (busy && !mem_req && c_phase == 1) ok = 1'b1;
        end
        check("reached WAIT", 64'(ok), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async rst");
        reset_model();
        d_req      = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        dn0 = d_done_cnt + i_done_cnt;
        for (int k = 0; k < 6; k++) cycle();
        check("no done after rst", 64'(d_done_cnt + i_done_cnt - dn0), 64'd0);
        run_vec(vecs[5], "post-rst");

        // ---- spurious rvalid in IDLE
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        exp_err    = 1'b1;
        cycle();
        check("spurious busy", 64'(busy), 64'd0);
        cycle();
        run_vec(vecs[6], "post-err I");
        run_vec(vecs[2], "post-err D");

        // ---- randomized traffic against the model
        rand_ctl = 1'b1;
        rand_req = 1'b1;
        g0  = grants;
        dn0 = d_done_cnt + i_done_cnt;
        for (int k = 0; k < 3000; k++) cycle();
        rand_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            cycle();
            if (!busy && !i_req && !d_req && c_phase == 0 && pend_side == 0) ok = 1'b1;
        end
        check("random drained", 64'(ok), 64'd1);
        check("random grants == dones", 64'(d_done_cnt + i_done_cnt - dn0), 64'(grants - g0));
        check("random had traffic", 64'((grants - g0) > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
